noc_packetizer_rr: RTL and testbench

Clocked, multi-channel successor to the single-source adder packetizer on the accelerator NoC. It takes partial-sum words from `NCH` producer channels and round-robin arbitrates among them. It wraps each word, or a packed group of up to `PACK` words from one channel, into one `PWIDTH`-bit NoC packet with type, destination, source and word-count fields. It sits between the adder/accumulator outputs and the local router injection port.

---
 rtl/noc_pkt_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/noc_packetizer_rr.sv | 133 +++++++++++++
 tb/tb_noc_packetizer_rr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkt_pkg.sv
// noc_pkt_pkg: shared field geometry, state encoding and header builder for the NoC packetizer
package noc_pkt_pkg;
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_NCH = 4;
  localparam int DEF_PACK = 4;
  localparam int DEF_AW = 3;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CW = $clog2(DEF_PACK + 1);
  localparam int DEF_HW = 1 + 2*DEF_AW + DEF_CW;
  localparam int DEF_PADW = 5;
  localparam int DEF_PWIDTH = DEF_HW + DEF_PADW + DEF_PACK*DEF_DWIDTH;
  localparam int WORDS_OFF = 0;
  localparam int PAD_OFF = DEF_PACK*DEF_DWIDTH;
  localparam int CNT_OFF = PAD_OFF + DEF_PADW;
  localparam int SRC_OFF = CNT_OFF + DEF_CW;
  localparam int DEST_OFF = SRC_OFF + DEF_AW;
  localparam int TYPE_OFF = DEST_OFF + DEF_AW;
  localparam logic [1023:0] FILL_ONES = '1;
  typedef enum logic [1:0] {IDLE, FILL, SEND} pkt_state_t;
  function automatic logic [63:0] mk_header(input logic t, input logic [31:0] dest,
                                            input logic [31:0] src, input logic [31:0] cnt,
                                            input int aw, input int cw);
    return (64'(t) << (2*aw + cw)) | (64'(dest) << (aw + cw)) | (64'(src) << cw) | 64'(cnt);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among requesters, pointer moves past the winner on advance
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int LW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [LW-1:0]  gidx
);
  logic [LW-1:0] ptr;
  int c;
  // scan from the farthest slot back to the pointer so the nearest requester wins last
  always_comb begin
    grant = '0;
    gidx = '0;
    c = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NCH;
      if (req[c]) begin
        grant = '0;
        grant[c] = 1'b1;
        gidx = LW'(c);
      end
    end
  end
  // pointer register: one past the granted channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= gidx == LW'(NCH - 1) ? '0 : gidx + LW'(1);
endmodule

// File: rtl/noc_packetizer_rr.sv
// noc_packetizer_rr: round-robin packetizer wrapping channel words into NoC packets
module noc_packetizer_rr
  import noc_pkt_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int NCH = DEF_NCH,
  parameter int PACK = DEF_PACK,
  parameter int AW = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*DWIDTH-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH*AW-1:0]     dest_addr,
  input  logic [AW-1:0]         src_addr,
  input  logic                  pkt_type,
  input  logic                  pack_en,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [PWIDTH-1:0]     out_data,
  input  logic                  out_ready
);
  localparam int CW = $clog2(PACK + 1);
  localparam int HW = 1 + 2*AW + CW;
  localparam int WW = PACK*DWIDTH;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int LW = NCH > 1 ? $clog2(NCH) : 1;
  pkt_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, ncnt, pcnt;
  logic [IW-1:0] idle, idle_n, nidle;
  logic [LW-1:0] lk, lk_n, gidx, widx;
  logic [WW-1:0] wbuf, wbuf_n, first, nxt, pw;
  logic [AW-1:0] dlat, dlat_n, pd;
  logic tlat, tlat_n, pt, pick, take, load;
  logic [NCH-1:0] grant;
  logic [DWIDTH-1:0] word;
  logic [PWIDTH-1:0] pkt;
  rr_arbiter #(.NCH(NCH), .LW(LW)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(in_valid),
    .advance(pick & |in_valid),
    .grant(grant),
    .gidx(gidx)
  );
  // handshake: FILL listens only to the locked channel, otherwise the arbiter picks once the output frees
  always_comb begin
    pick = rst_n && (state == IDLE || (state == SEND && out_ready));
    in_ready = !rst_n ? '0 : state == FILL ? NCH'(1) << lk : pick ? grant : '0;
    take = |(in_valid & in_ready);
    widx = state == FILL ? lk : gidx;
    word = in_data[widx*DWIDTH +: DWIDTH];
  end
  // packet assembly and next-state: accumulate in FILL, emit on full/flush/timeout or single word
  always_comb begin
    first = FILL_ONES[WW-1:0];
    first[DWIDTH-1:0] = word;
    nxt = wbuf;
    nxt[int'(cnt)*DWIDTH +: DWIDTH] = word;
    ncnt = cnt + CW'(take);
    nidle = take ? '0 : idle + IW'(1);
    state_n = state;
    cnt_n = cnt;
    idle_n = idle;
    wbuf_n = wbuf;
    lk_n = lk;
    dlat_n = dlat;
    tlat_n = tlat;
    load = 1'b0;
    pcnt = ncnt;
    pw = take ? nxt : wbuf;
    pd = dlat;
    pt = tlat;
    if (state == FILL) begin
      if (ncnt == CW'(PACK) || flush || nidle == IW'(TIMEOUT)) begin
        load = 1'b1;
        state_n = SEND;
        cnt_n = '0;
        idle_n = '0;
      end else begin
        cnt_n = ncnt;
        idle_n = nidle;
        wbuf_n = pw;
      end
    end else if (pick) begin
      if (take && pack_en && PACK > 1) begin
        state_n = FILL;
        cnt_n = CW'(1);
        idle_n = '0;
        wbuf_n = first;
        lk_n = gidx;
        dlat_n = dest_addr[gidx*AW +: AW];
        tlat_n = pkt_type;
      end else if (take) begin
        load = 1'b1;
        state_n = SEND;
        pcnt = CW'(1);
        pw = first;
        pd = dest_addr[gidx*AW +: AW];
        pt = pkt_type;
      end else state_n = IDLE;
    end
    pkt = {PWIDTH{1'b1}};
    pkt[PWIDTH-1 -: HW] = HW'(mk_header(pt, 32'(pd), 32'(src_addr), 32'(pcnt), AW, CW));
    pkt[WW-1:0] = pw;
  end
  // state and output register; a reset drops any partially filled packet
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idle <= '0;
      lk <= '0;
      wbuf <= '0;
      dlat <= '0;
      tlat <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idle <= idle_n;
      lk <= lk_n;
      wbuf <= wbuf_n;
      dlat <= dlat_n;
      tlat <= tlat_n;
      out_valid <= load | (out_valid & ~out_ready);
      if (load) out_data <= pkt;
    end
endmodule

// File: tb/tb_noc_packetizer_rr.sv
// tb_noc_packetizer_rr: directed plus random stimulus checked against a queue-based packet model
module tb_noc_packetizer_rr;
  localparam int DW = 8, N = 4, P = 4, AW = 3, TO = 16, PW = 47;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] in_valid, in_ready, last_rdy;
  logic [N*DW-1:0] in_data;
  logic [N*AW-1:0] dest_addr;
  logic [AW-1:0] src_addr;
  logic pkt_type, pack_en, flush, out_valid, out_ready;
  logic [PW-1:0] out_data, saved;
  int total = 0, bad = 0;
  int m_ptr, m_lock, m_idle;
  logic [7:0] m_q[$];
  logic [AW-1:0] m_dest;
  logic m_type, m_ov;
  logic [PW-1:0] m_out;
  int prev, idx;

  always #5 clk = ~clk;

  noc_packetizer_rr dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dest_addr(dest_addr), .src_addr(src_addr), .pkt_type(pkt_type), .pack_en(pack_en),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] build(input logic t, input logic [AW-1:0] d,
                                          input logic [AW-1:0] s, input logic [7:0] w[$]);
    logic [PW-1:0] p;
    logic [2:0] c;
    c = 3'(w.size());
    p = {t, d, s, c, 5'h1F, 32'hFFFF_FFFF};
    foreach (w[j]) p[j*8 +: 8] = w[j];
    return p;
  endfunction

  function automatic logic [N*DW-1:0] dat(input int ch, input logic [7:0] b);
    logic [N*DW-1:0] x;
    x = $urandom;
    x[ch*DW +: DW] = b;
    return x;
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    m_lock = -1;
    m_idle = 0;
    m_q.delete();
    m_ov = 1'b0;
    m_out = '0;
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic fl, input logic ordy);
    logic [N-1:0] er;
    int sel;
    logic [7:0] one[$];
    in_valid = v;
    in_data = d;
    flush = fl;
    out_ready = ordy;
    #1;
    er = '0;
    sel = -1;
    if (m_lock >= 0) er[m_lock] = 1'b1;
    else if (!m_ov || ordy) begin
      for (int k = 0; k < N; k++)
        if (sel < 0 && v[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      if (sel >= 0) er[sel] = 1'b1;
    end
    last_rdy = in_ready;
    chk("in_ready", in_ready, er);
    if (m_ov && ordy) m_ov = 1'b0;
    if (m_lock >= 0) begin
      if (v[m_lock]) begin
        m_q.push_back(d[m_lock*DW +: DW]);
        m_idle = 0;
      end else m_idle++;
      if (m_q.size() == P || fl || m_idle == TO) begin
        m_out = build(m_type, m_dest, src_addr, m_q);
        m_ov = 1'b1;
        m_q.delete();
        m_lock = -1;
        m_idle = 0;
      end
    end else if (sel >= 0) begin
      m_ptr = (sel + 1) % N;
      if (pack_en) begin
        m_lock = sel;
        m_q.delete();
        m_q.push_back(d[sel*DW +: DW]);
        m_dest = dest_addr[sel*AW +: AW];
        m_type = pkt_type;
        m_idle = 0;
      end else begin
        one.push_back(d[sel*DW +: DW]);
        m_out = build(pkt_type, dest_addr[sel*AW +: AW], src_addr, one);
        m_ov = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_out);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    dest_addr = '0;
    src_addr = 3'd4;
    pkt_type = 1'b1;
    pack_en = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    m_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    dest_addr = 12'(3) << 6;
    cyc(4'b0100, dat(2, 8'h5A), 1'b0, 1'b1);
    chk("single_pkt", out_data, 47'h5C3F_FFFF_FF5A);
    cyc(4'b0000, $urandom, 1'b0, 1'b1);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      dest_addr = $urandom;
      cyc(4'hF, $urandom, 1'b0, 1'b1);
      idx = -1;
      for (int b = 0; b < N; b++) if (last_rdy[b]) idx = b;
      if (i > 0) chk("rr_order", idx, (prev + 1) % N);
      prev = idx;
    end
    cyc(4'b0000, $urandom, 1'b0, 1'b1);
    pack_en = 1'b1;
    cyc(4'b0010, dat(1, 8'h01), 1'b0, 1'b1);
    cyc(4'b1111, dat(1, 8'h02), 1'b0, 1'b1);
    cyc(4'b1111, dat(1, 8'h03), 1'b0, 1'b1);
    cyc(4'b1111, dat(1, 8'h04), 1'b0, 1'b1);
    chk("pack_words", out_data[31:0], 32'h0403_0201);
    chk("pack_cnt", out_data[39:37], 4);
    cyc(4'b0000, $urandom, 1'b0, 1'b1);
    cyc(4'b0001, dat(0, 8'h11), 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) cyc(4'b0000, $urandom, 1'b0, 1'b1);
    chk("to_early", out_valid, 0);
    cyc(4'b0000, $urandom, 1'b0, 1'b1);
    chk("to_words", out_data[31:0], 32'hFFFF_FF11);
    chk("to_cnt", out_data[39:37], 1);
    cyc(4'b1000, dat(3, 8'hA1), 1'b0, 1'b1);
    cyc(4'b1000, dat(3, 8'hB2), 1'b0, 1'b1);
    cyc(4'b0000, $urandom, 1'b1, 1'b1);
    chk("flush_words", out_data[31:0], 32'hFFFF_B2A1);
    chk("flush_cnt", out_data[39:37], 2);
    cyc(4'b1000, dat(3, 8'hC3), 1'b0, 1'b1);
    cyc(4'b1000, dat(3, 8'hD4), 1'b1, 1'b1);
    chk("flush_acc_words", out_data[31:0], 32'hFFFF_D4C3);
    cyc(4'b0000, $urandom, 1'b1, 1'b1);
    pack_en = 1'b0;
    cyc(4'b0001, dat(0, 8'h77), 1'b0, 1'b1);
    saved = out_data;
    for (int i = 0; i < 5; i++) cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("hold_data", out_data, saved);
    cyc(4'hF, $urandom, 1'b0, 1'b1);
    cyc(4'b0000, $urandom, 1'b0, 1'b1);
    pack_en = 1'b1;
    cyc(4'b0001, dat(0, 8'h21), 1'b0, 1'b1);
    cyc(4'b0001, dat(0, 8'h22), 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midfill_out_valid", out_valid, 0);
    chk("midfill_out_data", out_data, 0);
    chk("midfill_in_ready", in_ready, 0);
    rst_n = 1'b1;
    cyc(4'b0100, dat(2, 8'h33), 1'b0, 1'b1);
    cyc(4'b0000, $urandom, 1'b1, 1'b1);
    chk("fresh_words", out_data[31:0], 32'hFFFF_FF33);
    for (int i = 0; i < 600; i++) begin
      pack_en = 1'($urandom_range(0, 1));
      pkt_type = 1'($urandom_range(0, 1));
      dest_addr = $urandom;
      src_addr = $urandom;
      cyc(((i / 60) % 2) ? ($urandom_range(0, 15) == 0 ? 4'($urandom) : 4'h0) : 4'($urandom),
          $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < TO + 2; i++) cyc(4'b0000, $urandom, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
